// File: rtl/dq_transform_scheduler_pkg.sv
// Shared definitions for the dq transform scheduler: the `SINGLE operand width,
// FSM state encoding, err_flags bit positions and the default engine latency.
`ifndef SINGLE
`define SINGLE 32
`endif

package dq_transform_scheduler_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } sched_state_e;

  // err_flags bit positions
  localparam int unsigned ErrOverrun = 0;
  localparam int unsigned ErrOrphan  = 1;
  localparam int unsigned ErrTimeout = 2;

  // Done delay of the abc2dq0 engine this scheduler is paired with
  localparam int unsigned DefaultLatency = 12;

endpackage

// File: rtl/dq_transform_scheduler_tag_pipe.sv
// Tag pipe: Depth-deep {valid, tag} shift register that runs in lockstep with the
// transform engine, so the tag leaving the last stage names the channel whose
// result the engine presents in the same cycle.
module dq_transform_scheduler_tag_pipe #(
  parameter int unsigned Depth = 12,
  parameter int unsigned TagW  = 3
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            push_valid_i,
  input  logic [TagW-1:0] push_tag_i,
  output logic            out_valid_o,
  output logic [TagW-1:0] out_tag_o,
  output logic            empty_o
);

  logic [Depth-1:0] vld_q;
  logic [TagW-1:0]  tag_q [Depth];

  // Shift one stage per clock; an idle cycle inserts a bubble with valid=0
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q <= '0;
      for (int i = 0; i < int'(Depth); i++) tag_q[i] <= '0;
    end else if (flush_i) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= push_valid_i;
      tag_q[0] <= push_tag_i;
      for (int i = 1; i < int'(Depth); i++) begin
        vld_q[i] <= vld_q[i-1];
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  // Empty once the output stage retires: nothing upstream and nothing entering
  always_comb begin
    empty_o = !push_valid_i;
    for (int i = 0; i < int'(Depth) - 1; i++) begin
      if (vld_q[i]) empty_o = 1'b0;
    end
  end

  assign out_valid_o = vld_q[Depth-1];
  assign out_tag_o   = tag_q[Depth-1];

endmodule

// File: rtl/dq_transform_scheduler.sv
// dq transform scheduler: shares one pipelined abc2dq0 engine across N_CH
// three-phase channels per simulation step. Snapshots the enabled channels and the
// PLL angle, issues one transform per clock, steers returning Vd/Vq into
// per-channel slots and pulses step_done when every issued result has landed.
// Optional build macro DQ_SCHED_TIMEOUT_EN adds a DRAIN timeout (err_flags[2]).
module dq_transform_scheduler
  import dq_transform_scheduler_pkg::*;
#(
  parameter int unsigned N_CH    = 4,
  parameter int unsigned LATENCY = DefaultLatency,
  parameter int unsigned TAG_W   = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      step_sta,
  input  logic [N_CH-1:0]           ch_mask,
  input  logic [N_CH*`SINGLE-1:0]   ch_va,
  input  logic [N_CH*`SINGLE-1:0]   ch_vb,
  input  logic [N_CH*`SINGLE-1:0]   ch_vc,
  input  logic [`SINGLE-1:0]        sin_theta,
  input  logic [`SINGLE-1:0]        cos_theta,
  output logic                      eng_sta,
  output logic [`SINGLE-1:0]        eng_va,
  output logic [`SINGLE-1:0]        eng_vb,
  output logic [`SINGLE-1:0]        eng_vc,
  output logic [`SINGLE-1:0]        eng_sin,
  output logic [`SINGLE-1:0]        eng_cos,
  input  logic [`SINGLE-1:0]        eng_vd,
  input  logic [`SINGLE-1:0]        eng_vq,
  input  logic                      eng_done,
  output logic [N_CH*`SINGLE-1:0]   vd_out,
  output logic [N_CH*`SINGLE-1:0]   vq_out,
  output logic [N_CH-1:0]           res_valid,
  output logic                      busy,
  output logic                      step_done,
  output logic [2:0]                err_flags
);

  localparam int unsigned W = `SINGLE;

  sched_state_e state_q, state_d;

  logic [N_CH-1:0]   pend_q, mask_q, pend_clr;
  logic [N_CH*W-1:0] snap_va_q, snap_vb_q, snap_vc_q;
  logic [W-1:0]      snap_sin_q, snap_cos_q;
  logic [TAG_W-1:0]  sel_idx, sel_q, op_idx;
  logic [N_CH*W-1:0] vd_q, vq_q;
  logic [N_CH-1:0]   res_valid_q, res_valid_d;
  logic [2:0]        err_q, err_d;
  logic              busy_q;
  logic              accept, issue, flush, capture, cap_pending;
  logic              pipe_valid, pipe_empty;
  logic [TAG_W-1:0]  pipe_tag;

`ifdef DQ_SCHED_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(LATENCY + 6);
  logic [CntW-1:0] cnt_q;
`endif

  // Lowest-index pending channel; pend_clr is the pending set after issuing it
  always_comb begin
    sel_idx = '0;
    for (int i = int'(N_CH) - 1; i >= 0; i--) begin
      if (pend_q[i]) sel_idx = TAG_W'(i);
    end
    pend_clr = pend_q & ~(N_CH'(1) << sel_idx);
  end

  // Operands follow the channel being issued, otherwise hold the last one
  always_comb begin
    op_idx  = (state_q == StIssue) ? sel_idx : sel_q;
    eng_va  = snap_va_q[int'(op_idx)*W +: W];
    eng_vb  = snap_vb_q[int'(op_idx)*W +: W];
    eng_vc  = snap_vc_q[int'(op_idx)*W +: W];
    eng_sin = snap_sin_q;
    eng_cos = snap_cos_q;
  end

  // Result capture and the pending-capture check that gates the end of DRAIN
  always_comb begin
    capture     = eng_done && pipe_valid;
    res_valid_d = res_valid_q;
    if (capture) res_valid_d = res_valid_q | (N_CH'(1) << pipe_tag);
    cap_pending = (mask_q & ~res_valid_d) != '0;
  end

  // Next-state, issue strobe and sticky error flags
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    issue   = 1'b0;
    flush   = 1'b0;
    err_d   = err_q;
    if (step_sta && state_q != StIdle) err_d[ErrOverrun] = 1'b1;
    if (eng_done && !pipe_valid)       err_d[ErrOrphan]  = 1'b1;
    unique case (state_q)
      StIdle: begin
        if (step_sta) begin
          if (ch_mask != '0) begin
            accept  = 1'b1;
            state_d = StIssue;
          end else begin
            state_d = StDone;
          end
        end
      end
      StIssue: begin
        issue = 1'b1;
        if (pend_clr == '0) state_d = StDrain;
      end
      StDrain: begin
        if (pipe_empty && !cap_pending) begin
          state_d = StDone;
`ifdef DQ_SCHED_TIMEOUT_EN
        end else if (cnt_q > CntW'(LATENCY + 4)) begin
          flush             = 1'b1;
          err_d[ErrTimeout] = 1'b1;
          state_d           = StDone;
`endif
        end
      end
      StDone: state_d = StIdle;
    endcase
  end

  // State, snapshot, result slots and flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      pend_q      <= '0;
      mask_q      <= '0;
      snap_va_q   <= '0;
      snap_vb_q   <= '0;
      snap_vc_q   <= '0;
      snap_sin_q  <= '0;
      snap_cos_q  <= '0;
      sel_q       <= '0;
      vd_q        <= '0;
      vq_q        <= '0;
      res_valid_q <= '0;
      err_q       <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      if (accept) begin
        pend_q      <= ch_mask;
        mask_q      <= ch_mask;
        snap_va_q   <= ch_va;
        snap_vb_q   <= ch_vb;
        snap_vc_q   <= ch_vc;
        snap_sin_q  <= sin_theta;
        snap_cos_q  <= cos_theta;
        res_valid_q <= '0;
        busy_q      <= 1'b1;
      end else begin
        res_valid_q <= res_valid_d;
      end
      if (issue) begin
        pend_q <= pend_clr;
        sel_q  <= sel_idx;
      end
      if (capture) begin
        vd_q[int'(pipe_tag)*W +: W] <= eng_vd;
        vq_q[int'(pipe_tag)*W +: W] <= eng_vq;
      end
      if (state_q == StDone) busy_q <= 1'b0;
    end
  end

`ifdef DQ_SCHED_TIMEOUT_EN
  // Counts cycles spent in DRAIN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (state_q == StDrain) begin
      cnt_q <= cnt_q + 1'b1;
    end else begin
      cnt_q <= '0;
    end
  end
`endif

  dq_transform_scheduler_tag_pipe #(
    .Depth (LATENCY),
    .TagW  (TAG_W)
  ) u_tag_pipe (
    .clk_i        (clk),
    .rst_i        (rst),
    .flush_i      (flush),
    .push_valid_i (issue),
    .push_tag_i   (sel_idx),
    .out_valid_o  (pipe_valid),
    .out_tag_o    (pipe_tag),
    .empty_o      (pipe_empty)
  );

  assign eng_sta   = (state_q == StIssue);
  assign step_done = (state_q == StDone);
  assign busy      = busy_q;
  assign res_valid = res_valid_q;
  assign vd_out    = vd_q;
  assign vq_out    = vq_q;
  assign err_flags = err_q;

endmodule

// File: tb/tb_dq_transform_scheduler.sv
// Directed bench for dq_transform_scheduler. The engine stand-in is a 12-deep
// delay line returning vd = va ^ cos and vq = va ^ vb ^ vc ^ sin, so every slot
// value can be worked out by hand from the operands of its channel.
`ifndef SINGLE
`define SINGLE 32
`endif

module tb_dq_transform_scheduler;

  localparam int L = 12;

  logic         clk = 1'b0;
  logic         rst;
  logic         step_sta;
  logic [3:0]   ch_mask;
  logic [127:0] ch_va, ch_vb, ch_vc;
  logic [31:0]  sin_theta, cos_theta;
  logic         eng_sta;
  logic [31:0]  eng_va, eng_vb, eng_vc, eng_sin, eng_cos;
  logic [31:0]  eng_vd, eng_vq;
  logic         eng_done;
  logic [127:0] vd_out, vq_out;
  logic [3:0]   res_valid;
  logic         busy, step_done;
  logic [2:0]   err_flags;

  int n_checks = 0;
  int n_err    = 0;

  logic         spur_done = 1'b0;
  logic         drop_en   = 1'b0;
  logic [L-1:0] m_v = '0;
  logic [31:0]  m_vd [L];
  logic [31:0]  m_vq [L];

  logic [31:0]  iss_va [8];
  int           n_iss;

  always #5 clk = ~clk;

  dq_transform_scheduler dut (
    .clk       (clk),
    .rst       (rst),
    .step_sta  (step_sta),
    .ch_mask   (ch_mask),
    .ch_va     (ch_va),
    .ch_vb     (ch_vb),
    .ch_vc     (ch_vc),
    .sin_theta (sin_theta),
    .cos_theta (cos_theta),
    .eng_sta   (eng_sta),
    .eng_va    (eng_va),
    .eng_vb    (eng_vb),
    .eng_vc    (eng_vc),
    .eng_sin   (eng_sin),
    .eng_cos   (eng_cos),
    .eng_vd    (eng_vd),
    .eng_vq    (eng_vq),
    .eng_done  (eng_done),
    .vd_out    (vd_out),
    .vq_out    (vq_out),
    .res_valid (res_valid),
    .busy      (busy),
    .step_done (step_done),
    .err_flags (err_flags)
  );

  // Engine stand-in; drop_en swallows the result of the operand set va=12345678
  always @(posedge clk) begin
    if (rst) begin
      m_v <= '0;
    end else begin
      m_v   <= {m_v[L-2:0], eng_sta && !(drop_en && eng_va == 32'h12345678)};
      m_vd[0] <= eng_va ^ eng_cos;
      m_vq[0] <= eng_va ^ eng_vb ^ eng_vc ^ eng_sin;
      for (int i = 1; i < L; i++) begin
        m_vd[i] <= m_vd[i-1];
        m_vq[i] <= m_vq[i-1];
      end
    end
  end

  assign eng_done = m_v[L-1] | spur_done;
  assign eng_vd   = m_vd[L-1];
  assign eng_vq   = m_vq[L-1];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] slot(input logic [127:0] v, input int i);
    return v[i*32 +: 32];
  endfunction

  task automatic set_ch(input int i, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c);
    ch_va[i*32 +: 32] = a;
    ch_vb[i*32 +: 32] = b;
    ch_vc[i*32 +: 32] = c;
  endtask

  task automatic load_set_a();
    set_ch(0, 32'h40000000, 32'hc0000000, 32'h00000000);
    set_ch(1, 32'h3f800000, 32'h3f800000, 32'hbf800000);
    set_ch(2, 32'h12345678, 32'h00000000, 32'h00000000);
    set_ch(3, 32'h41200000, 32'hc0a00000, 32'hc0a00000);
    sin_theta = 32'h3f000000;
    cos_theta = 32'h3f5db3d7;
  endtask

  task automatic load_set_unit();
    set_ch(0, 32'h3f800000, 32'hbf000000, 32'hbf000000);
    sin_theta = 32'h00000000;
    cos_theta = 32'h3f800000;
  endtask

  // Called at a falling edge: step_sta is sampled by the next rising edge (edge 0)
  task automatic start_step(input logic [3:0] m);
    ch_mask  = m;
    step_sta = 1'b1;
  endtask

  // Observes cycles 1..max_cyc; optional second step_sta in cycle inj_cyc
  task automatic run_step(input int max_cyc, input int inj_cyc, input logic scramble,
                          output int done_cyc, output logic [63:0] sta_cyc,
                          output logic busy_seen);
    done_cyc  = 0;
    sta_cyc   = '0;
    busy_seen = 1'b0;
    n_iss     = 0;
    for (int n = 1; n <= max_cyc && done_cyc == 0; n++) begin
      @(negedge clk);
      step_sta = (n == inj_cyc);
      if (n == inj_cyc) ch_mask = 4'b0001;
      if (n == 1 && scramble) begin
        ch_va = '1; ch_vb = '1; ch_vc = '1;
        sin_theta = '1; cos_theta = '1;
      end
      if (eng_sta) begin
        sta_cyc[n] = 1'b1;
        if (n_iss < 8) iss_va[n_iss] = eng_va;
        n_iss++;
      end
      if (busy) busy_seen = 1'b1;
      if (step_done) done_cyc = n;
    end
    step_sta = 1'b0;
    @(negedge clk);
  endtask

  int          done_cyc;
  logic [63:0] sta_cyc;
  logic        busy_seen;
  int          late_done;

  initial begin
    rst = 1'b1;
    step_sta = 1'b0;
    ch_mask = '0;
    ch_va = '0; ch_vb = '0; ch_vc = '0;
    sin_theta = '0; cos_theta = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_eng_sta", 128'(eng_sta), 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_step_done", 128'(step_done), 128'd0);
    check("rst_res_valid", 128'(res_valid), 128'd0);
    check("rst_err", 128'(err_flags), 128'd0);
    check("rst_vd_out", vd_out, 128'd0);

    // 1: single channel, unit-angle transform
    load_set_unit();
    start_step(4'b0001);
    run_step(30, 0, 1'b0, done_cyc, sta_cyc, busy_seen);
    check("t1_done_cycle", 128'(done_cyc), 128'd14);
    check("t1_sta_cycles", 128'(sta_cyc), 128'h2);
    check("t1_vq0", 128'(slot(vq_out, 0)), 128'h3f800000);
    check("t1_vd0", 128'(slot(vd_out, 0)), 128'h00000000);
    check("t1_res_valid", 128'(res_valid), 128'b0001);
    check("t1_busy_seen", 128'(busy_seen), 128'd1);

    // 2: sparse mask, inputs scrambled after the snapshot
    load_set_a();
    start_step(4'b1011);
    run_step(30, 0, 1'b1, done_cyc, sta_cyc, busy_seen);
    check("t2_done_cycle", 128'(done_cyc), 128'd16);
    check("t2_sta_cycles", 128'(sta_cyc), 128'he);
    check("t2_issue0", 128'(iss_va[0]), 128'h40000000);
    check("t2_issue1", 128'(iss_va[1]), 128'h3f800000);
    check("t2_issue2", 128'(iss_va[2]), 128'h41200000);
    check("t2_vd0", 128'(slot(vd_out, 0)), 128'h7f5db3d7);
    check("t2_vq0", 128'(slot(vq_out, 0)), 128'hbf000000);
    check("t2_vd1", 128'(slot(vd_out, 1)), 128'h00ddb3d7);
    check("t2_vq1", 128'(slot(vq_out, 1)), 128'h80800000);
    check("t2_vd2_untouched", 128'(slot(vd_out, 2)), 128'h0);
    check("t2_vd3", 128'(slot(vd_out, 3)), 128'h7e7db3d7);
    check("t2_vq3", 128'(slot(vq_out, 3)), 128'h7e200000);
    check("t2_res_valid", 128'(res_valid), 128'b1011);

    // 3: empty mask
    start_step(4'b0000);
    run_step(10, 0, 1'b0, done_cyc, sta_cyc, busy_seen);
    check("t3_done_cycle", 128'(done_cyc), 128'd1);
    check("t3_sta_cycles", 128'(sta_cyc), 128'h0);
    check("t3_busy_seen", 128'(busy_seen), 128'd0);

    // 4: overrun in cycle 5 of a 4-channel step
    load_set_a();
    start_step(4'b1111);
    run_step(40, 5, 1'b0, done_cyc, sta_cyc, busy_seen);
    check("t4_done_cycle", 128'(done_cyc), 128'd17);
    check("t4_sta_cycles", 128'(sta_cyc), 128'h1e);
    check("t4_err", 128'(err_flags), 128'b001);
    check("t4_res_valid", 128'(res_valid), 128'b1111);
    check("t4_vd2", 128'(slot(vd_out, 2)), 128'h2d69e5af);
    check("t4_vq2", 128'(slot(vq_out, 2)), 128'h2d345678);

    // 5: reset in cycle 8 aborts the step
    load_set_a();
    start_step(4'b1111);
    @(negedge clk);
    step_sta = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    #1;
    check("t5_eng_sta", 128'(eng_sta), 128'd0);
    check("t5_busy", 128'(busy), 128'd0);
    check("t5_step_done", 128'(step_done), 128'd0);
    check("t5_res_valid", 128'(res_valid), 128'd0);
    check("t5_err", 128'(err_flags), 128'd0);
    check("t5_vd_out", vd_out, 128'd0);
    check("t5_vq_out", vq_out, 128'd0);
    check("t5_eng_va", 128'(eng_va), 128'd0);
    @(negedge clk);
    rst = 1'b0;
    late_done = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (step_done) late_done++;
    end
    check("t5_no_step_done", 128'(late_done), 128'd0);
    load_set_unit();
    start_step(4'b0001);
    run_step(30, 0, 1'b0, done_cyc, sta_cyc, busy_seen);
    check("t5_rerun_done", 128'(done_cyc), 128'd14);
    check("t5_rerun_vq0", 128'(slot(vq_out, 0)), 128'h3f800000);
    check("t5_rerun_res", 128'(res_valid), 128'b0001);

    // 6: spurious eng_done while idle is an orphan
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    @(negedge clk);
    check("t6_orphan_err", 128'(err_flags), 128'b010);
    check("t6_busy_idle", 128'(busy), 128'd0);

`ifdef DQ_SCHED_TIMEOUT_EN
    // 6b: the ch2 result never returns, DRAIN times out
    drop_en = 1'b1;
    load_set_a();
    start_step(4'b1111);
    run_step(80, 0, 1'b0, done_cyc, sta_cyc, busy_seen);
    drop_en = 1'b0;
    check("t6_timeout_done_seen", 128'(done_cyc != 0), 128'd1);
    check("t6_timeout_err", 128'(err_flags), 128'b110);
    check("t6_timeout_res", 128'(res_valid), 128'b1011);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/dq_transform_scheduler.md
Name: dq_transform_scheduler

Overview:
Time-multiplexes a single pipelined abc2dq0 engine across N_CH three-phase channels, such as grid voltage, inverter current and filter-capacitor voltage, within one simulation step.
- On a step start it snapshots every enabled channel's abc samples and the shared sin/cos angle.
- It issues one transform per clock into the engine and tags each issue.
- It routes returning Vd/Vq results to per-channel holding registers, then signals step completion to the solver sequencer.

Parameters:
N_CH, 4, number of channels sharing the engine (1..8)
LATENCY, 12, engine sta-to-done latency in clocks; must equal the engine's done delay
TAG_W, 3, channel index width; must satisfy 2^TAG_W >= N_CH

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
step_sta  in  1  one-cycle pulse: start of simulation step
ch_mask  in  N_CH  channels to transform this step; sampled with step_sta
ch_va, ch_vb, ch_vc  in  N_CH*`SINGLE each  per-channel phase samples, channel i at [i*`SINGLE +: `SINGLE]
sin_theta, cos_theta  in  `SINGLE each  PLL angle; shared by all channels
eng_sta  out  1  issue strobe to the engine
eng_va, eng_vb, eng_vc, eng_sin, eng_cos  out  `SINGLE each  engine operands
eng_vd, eng_vq  in  `SINGLE each  engine results
eng_done  in  1  engine result-valid strobe
vd_out, vq_out  out  N_CH*`SINGLE each  per-channel results, held until overwritten
res_valid  out  N_CH  per-channel result captured this step
busy  out  1  high from step acceptance until step_done
step_done  out  1  one-cycle completion pulse
err_flags  out  3  sticky flags: [0] overrun, [1] orphan done, [2] timeout

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, tag pipeline cleared. Reset mid-step aborts the step; no step_done is issued.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - step_sta=1 with nonzero mask: snapshot ch_va/vb/vc, sin_theta, cos_theta and the mask into local registers; clear res_valid; go to ISSUE.
  - step_sta=1 with mask=0: go to DONE.
- ISSUE: each cycle, select the lowest-index pending channel.
  - Drive eng_sta=1 with that channel's snapshot operands and the snapshot angle; clear its pending bit.
  - Push {valid, tag} into a LATENCY-deep tag shift register.
  - When the last pending channel is issued, go to DRAIN.
  - eng_sta is 0 on every other cycle; operands hold their last values.
- Tag pipeline: shifts every cycle. A bubble enters with valid=0.
- Capture: when eng_done=1 and the tag at pipeline output is valid, write eng_vd/eng_vq into slot[tag] and set res_valid[tag] on the same edge.
- DRAIN: when the tag pipeline is empty and no capture is pending, go to DONE.
- DONE: step_done=1 for exactly one cycle, then return to IDLE. busy=0 in IDLE only.
- Timing (step_sta sampled at edge 0, K enabled channels):
  - eng_sta high in cycles 1..K.
  - eng_done expected in cycles 1+LATENCY..K+LATENCY.
  - step_done high in cycle K+LATENCY+1.
  - For K=0, step_done is high in cycle 1.
- Boundaries:
  - step_sta while busy: ignored; set err_flags[0].
  - eng_done with an invalid output tag: result discarded; set err_flags[1].
  - Valid output tag without eng_done: the tag is dropped; no capture for that channel.
  - step_sta in the DONE cycle counts as busy.
- err_flags clear only on rst.
- Snapshot inputs may change freely after step_sta without affecting the current step.

Optional Feature:
DQ_SCHED_TIMEOUT_EN
- Defined: a counter runs in DRAIN. If it exceeds LATENCY+4 cycles, set err_flags[2], flush the tag pipeline and go to DONE; res_valid then shows the missing channels.
- Undefined: no counter; DRAIN waits indefinitely; err_flags[2] is tied 0.

Decomposition:
- Shared package/include (alongside Global_parameter.v): `SINGLE, FSM state encodings, err_flags bit indices, default LATENCY matching abc2dq0.
- One natural sub-module: dq_tag_pipe, a LATENCY-deep {valid, tag} shift register with an empty indicator.

Test Plan:
1. mask=4'b0001, va=3f800000, vb=vc=bf000000, sin=00000000, cos=3f800000, step_sta -> eng_sta in cycle 1 only; vq_out[0]=3f800000, vd_out[0]=00000000; res_valid=0001; step_done in cycle 14.
2. mask=4'b1011, distinct samples per channel -> issues in order ch0, ch1, ch3 in cycles 1..3; each slot holds its own result; res_valid=1011; step_done in cycle 16.
3. mask=0, step_sta -> step_done in cycle 1; eng_sta never asserted; busy never high.
4. Second step_sta in cycle 5 of a 4-channel step -> ignored; err_flags=001; first step completes normally in cycle 17.
5. rst asserted in cycle 8 of a step -> all outputs 0 immediately; no step_done; a following step runs normally.
6. With DQ_SCHED_TIMEOUT_EN defined, the bench model suppresses eng_done for ch2 -> err_flags[2]=1; step_done asserts; res_valid[2]=0. With it undefined, a spurious eng_done in IDLE sets err_flags[1].
